compressor_cpa_pipe: RTL



---
 rtl/compressor_cpa_pipe.sv | 88 ++++++++
 1 files changed

// File: rtl/compressor_cpa_pipe.sv
`default_nettype none
// ============================================================================
// Module      : compressor_cpa_pipe
// Description : Two-stage pipelined carry-propagate adder that resolves a
//               redundant sum/carry pair into s + 2*c, with valid/ready flow.
// Revision    : 1.0  initial release
// ============================================================================
module compressor_cpa_pipe #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   s,
    input  logic [W-1:0]   c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+1:0]   sum
);

    localparam int H = W / 2;

    // Stage 1 state
    logic           r_v1;
    logic [H-1:0]   r_lo1;
    logic           r_k1;
    logic [H-1:0]   r_shi;
    logic [H:0]     r_chi;

    // Stage 2 state
    logic           r_v2;
    logic [H-1:0]   r_lo2;
    logic [H+1:0]   r_hi;

    logic           w_load1;
    logic           w_load2;
    logic [H:0]     w_lo;
    logic [H+1:0]   w_hi;

    // Both ready terms are combinational from out_ready so a full pipe can
    // pop and push in the same cycle.
    assign w_load2  = !r_v2 || out_ready;
    assign w_load1  = !r_v1 || w_load2;
    assign in_ready = w_load1;

    // Low half: carry vector is shifted by one, so c[H-1] belongs to the high half.
    assign w_lo = {1'b0, s[H-1:0]} + {1'b0, c[H-2:0], 1'b0};

    assign w_hi = {2'b00, r_shi} + {1'b0, r_chi} + {{(H+1){1'b0}}, r_k1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_lo1 <= '0;
            r_k1  <= 1'b0;
            r_shi <= '0;
            r_chi <= '0;
        end else if (w_load1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_lo1 <= w_lo[H-1:0];
                r_k1  <= w_lo[H];
                r_shi <= s[W-1:H];
                r_chi <= c[W-1:H-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2  <= 1'b0;
            r_lo2 <= '0;
            r_hi  <= '0;
        end else if (w_load2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_lo2 <= r_lo1;
                r_hi  <= w_hi;
            end
        end
    end

    assign out_valid = r_v2;
    assign sum       = {r_hi, r_lo2};

endmodule
`default_nettype wire
